video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 800, active pixels per line.
REQ-002 SHALL provide parameter H_FP, default 40; H_SYNC, default 128; H_BP, default 88 (pixel clocks).
REQ-003 SHALL provide parameter V_ACTIVE, default 600; V_FP, default 1; V_SYNC, default 4; V_BP, default 23 (lines).
REQ-004 SHALL provide parameter HS_POL, default 1, and VS_POL, default 1, sync assertion level.
REQ-005 SHALL provide parameter LOCK_STABLE, default 1024, consecutive locked cycles before output starts.
REQ-006 I_pxl_clk  in  1  pixel clock, 40 MHz (PLL CLKOUT1); one clock, no other clock domains.
REQ-007 I_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 I_pll_lock  in  1  PLL LOCK, asynchronous to I_pxl_clk.
REQ-009 O_run  out  1  timing running; serializer/encoder enable.
REQ-010 O_hs  out  1  horizontal sync at HS_POL level during sync.
REQ-011 O_vs  out  1  vertical sync at VS_POL level during sync.
REQ-012 O_de  out  1  active video.
REQ-013 O_x  out  12  pixel column, valid when O_de.
REQ-014 O_y  out  12  pixel row, valid when O_de.
REQ-015 O_sof  out  1  one-cycle pulse with first active pixel of each frame.

Function
REQ-016 I_pll_lock SHALL pass a 2-flop synchronizer before use; lock-to-FSM latency 2 cycles.
REQ-017 FSM states SHALL be WAIT_LOCK, STABLE, RUN.
REQ-018 WAIT_LOCK -> STABLE when synced lock = 1; stability counter cleared on entry.
REQ-019 STABLE: counter increments each cycle with lock = 1; -> RUN when count reaches LOCK_STABLE-1.
REQ-020 Any state, synced lock = 0 -> WAIT_LOCK next cycle; counters and outputs return to idle values.
REQ-021 Outside RUN: O_run=0, O_de=0, O_sof=0, O_hs=!HS_POL, O_vs=!VS_POL, O_x=0, O_y=0.
REQ-022 In RUN, h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1056), wrap to 0.
REQ-023 v_cnt SHALL increment on h_cnt wrap, range 0..V_TOTAL-1 (V_TOTAL = 628), wrap to 0 on simultaneous h and v terminal count.
REQ-024 Counters SHALL start at h_cnt=0, v_cnt=0 on the first RUN cycle.
REQ-025 Region order per line/frame: active, front porch, sync, back porch.
REQ-026 Raw de = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
REQ-027 Raw hs active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (h 840..967).
REQ-028 Raw vs active for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (lines 601..604), aligned to h_cnt = 0.
REQ-029 All outputs SHALL be registered, 1 cycle after the counter values; O_hs, O_vs, O_de, O_x, O_y mutually aligned.
REQ-030 O_x = h_cnt, O_y = v_cnt when de, else 0.
REQ-031 O_sof = 1 iff h_cnt = 0 and v_cnt = 0 (registered with same latency).
REQ-032 O_run SHALL assert in the same cycle as the first registered RUN outputs.
REQ-033 Counters SHALL be 12 bits; parameter sums above 4095 are a configuration error, checked by elaboration assertion.

Reset
REQ-034 I_rst_n low SHALL asynchronously force WAIT_LOCK, sync flops 0, all counters 0, outputs to REQ-021 values.
REQ-035 Reset release SHALL be synchronous-safe: first state change no earlier than the second I_pxl_clk edge after deassertion.
REQ-036 Reset mid-frame SHALL abort the frame; no partial sync pulse completes after deassertion.

Structure
REQ-037 Package video_timing_pkg SHALL hold the 800x600@60 timing constants, the FSM state typedef, and the counter width (12).
REQ-038 Sub-module lock_sync (2-flop synchronizer) SHALL be separate; the timing counters stay in video_timing_gen.

Verification
REQ-039 Reset, then lock=1 held -> O_run rises 2+LOCK_STABLE+1 cycles later (±1 for the synchronizer edge); O_sof coincides, O_x=0, O_y=0.
REQ-040 Free run for 2 frames -> 1056 clocks/line, 628 lines/frame, 800 O_de clocks/line, 600 active lines, O_hs high for 128 clocks starting at x=840, O_vs high 4 lines starting at line 601.
REQ-041 Lock pulse of 500 cycles, low, then held -> no RUN during the first pulse; stability counter restarts from 0.
REQ-042 Lock dropped at line 300, x=400 -> 3 cycles later O_run=0, O_de=0, syncs inactive; relock restarts the frame at x=0, y=0.
REQ-043 I_rst_n pulsed low during the vsync line -> outputs idle immediately (asynchronous); no residual O_vs after release.
REQ-044 Parameter set 640x480 (16/96/48, 10/2/33, HS_POL=VS_POL=0) -> 800x525 totals, active-low syncs.

Source files
------------

// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
// Shared definitions for the video timing generator:
//   - counter width and its maximum representable value
//   - 800x600@60 (40 MHz pixel clock) timing constants used as defaults
//   - FSM state type for the lock / stabilise / run sequencer
// -----------------------------------------------------------------------------
package video_timing_pkg;

    localparam int CNT_W   = 12;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // 800x600@60, pixel clocks per region
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;

    // 800x600@60, lines per region
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;

    localparam int DEFAULT_LOCK_STABLE = 1024;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } vtg_state_e;

endpackage

// File: rtl/lock_sync.sv
// -----------------------------------------------------------------------------
// lock_sync
// Two-flop synchronizer bringing the PLL lock indicator into the pixel clock
// domain. Both flops clear on reset so a fresh lock is always required after
// reset release.
//   clk_i         pixel clock
//   rst_ni        asynchronous active-low reset
//   lock_async_i  PLL LOCK, asynchronous to clk_i
//   lock_sync_o   synchronized lock, 2 clk_i cycles of latency
// -----------------------------------------------------------------------------
module lock_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic lock_async_i,
    output logic lock_sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= lock_async_i;
            sync_q <= meta_q;
        end
    end

    assign lock_sync_o = sync_q;

endmodule

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Raster timing generator gated by PLL lock. After the synchronized lock has
// been stable for LOCK_STABLE cycles the generator starts a frame at x=0, y=0
// and produces registered sync / data-enable / coordinate outputs. Loss of
// lock or reset returns everything to idle.
//   I_pxl_clk   pixel clock (only clock)
//   I_rst_n     asynchronous active-low reset
//   I_pll_lock  PLL lock, asynchronous
//   O_run       timing running (serializer/encoder enable)
//   O_hs, O_vs  syncs, at HS_POL / VS_POL level while in sync
//   O_de        active video
//   O_x, O_y    pixel column / row while O_de, else 0
//   O_sof       one-cycle pulse with the first active pixel of each frame
// -----------------------------------------------------------------------------
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE    = SVGA_H_ACTIVE,
    parameter int H_FP        = SVGA_H_FP,
    parameter int H_SYNC      = SVGA_H_SYNC,
    parameter int H_BP        = SVGA_H_BP,
    parameter int V_ACTIVE    = SVGA_V_ACTIVE,
    parameter int V_FP        = SVGA_V_FP,
    parameter int V_SYNC      = SVGA_V_SYNC,
    parameter int V_BP        = SVGA_V_BP,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1,
    parameter int LOCK_STABLE = DEFAULT_LOCK_STABLE
) (
    input  logic             I_pxl_clk,
    input  logic             I_rst_n,
    input  logic             I_pll_lock,
    output logic             O_run,
    output logic             O_hs,
    output logic             O_vs,
    output logic             O_de,
    output logic [CNT_W-1:0] O_x,
    output logic [CNT_W-1:0] O_y,
    output logic             O_sof
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);

    // Stability counter only needs to reach LOCK_STABLE-1.
    localparam int STAB_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST_C = STAB_W'(LOCK_STABLE - 1);

    generate
        if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_cfg_err_width
            $error("video_timing_gen: H/V totals exceed counter range");
        end
        if (LOCK_STABLE < 1) begin : g_cfg_err_lock
            $error("video_timing_gen: LOCK_STABLE must be at least 1");
        end
    endgenerate

    logic lock_s;

    lock_sync u_lock_sync (
        .clk_i        (I_pxl_clk),
        .rst_ni       (I_rst_n),
        .lock_async_i (I_pll_lock),
        .lock_sync_o  (lock_s)
    );

    vtg_state_e        state_q, state_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [CNT_W-1:0]  h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]  v_cnt_q, v_cnt_d;
    logic              run_en;
    logic              stab_inc;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (!lock_s) begin
            state_d = WAIT_LOCK;
        end else begin
            case (state_q)
                WAIT_LOCK: state_d = STABLE;
                STABLE:    if (stab_q == STAB_LAST_C) state_d = RUN;
                RUN:       state_d = RUN;
                default:   state_d = WAIT_LOCK;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // Gating with lock_s makes the raster go idle in the same cycle lock is
    // seen low, rather than one cycle later when the state register follows.
    always_comb begin
        run_en   = (state_q == RUN) && lock_s;
        stab_inc = (state_q == STABLE) && lock_s;
    end

    // Stability counter and raster counters. Anything other than an active
    // STABLE / RUN cycle clears them, so every entry starts from zero.
    always_comb begin
        stab_d  = stab_inc ? stab_q + 1'b1 : '0;
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (run_en) begin
            if (h_cnt_q == H_LAST_C) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
                v_cnt_d = v_cnt_q;
            end
        end
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            stab_q  <= '0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            stab_q  <= stab_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // ---------------- Registered raster outputs ----------------
    logic raw_de, raw_hs, raw_vs, raw_sof;

    always_comb begin
        raw_de  = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        raw_hs  = (h_cnt_q >= HS_BEG_C) && (h_cnt_q < HS_END_C);
        raw_vs  = (v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C);
        raw_sof = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_run <= 1'b0;
            O_hs  <= ~HS_POL;
            O_vs  <= ~VS_POL;
            O_de  <= 1'b0;
            O_sof <= 1'b0;
            O_x   <= '0;
            O_y   <= '0;
        end else if (run_en) begin
            O_run <= 1'b1;
            O_hs  <= raw_hs ? HS_POL : ~HS_POL;
            O_vs  <= raw_vs ? VS_POL : ~VS_POL;
            O_de  <= raw_de;
            O_sof <= raw_sof;
            O_x   <= raw_de ? h_cnt_q : '0;
            O_y   <= raw_de ? v_cnt_q : '0;
        end else begin
            O_run <= 1'b0;
            O_hs  <= ~HS_POL;
            O_vs  <= ~VS_POL;
            O_de  <= 1'b0;
            O_sof <= 1'b0;
            O_x   <= '0;
            O_y   <= '0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
// Two generators share clock, reset and lock: A uses a small active-high
// raster, B a different small active-low raster. The reference model counts
// how long the FSM-visible lock (input delayed two edges) has been high; from
// that run time alone it derives the frame position and every expected output.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

    localparam int A_HA = 40, A_HFP = 4, A_HS = 8, A_HBP = 6;
    localparam int A_VA = 20, A_VFP = 2, A_VS = 3, A_VBP = 4;
    localparam int A_LS = 16;
    localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;   // 58
    localparam int A_VT = A_VA + A_VFP + A_VS + A_VBP;   // 29
    localparam int A_FRAME = A_HT * A_VT;

    localparam int B_HA = 32, B_HFP = 3, B_HS = 5, B_HBP = 4;
    localparam int B_VA = 12, B_VFP = 1, B_VS = 2, B_VBP = 3;
    localparam int B_LS = 10;
    localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;   // 44
    localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;   // 18
    localparam int B_FRAME = B_HT * B_VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lock = 1'b0;

    logic a_run, a_hs, a_vs, a_de, a_sof;
    logic [11:0] a_x, a_y;
    logic b_run, b_hs, b_vs, b_de, b_sof;
    logic [11:0] b_x, b_y;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_STABLE(A_LS)
    ) u_dut_a (
        .I_pxl_clk(clk), .I_rst_n(rst_n), .I_pll_lock(lock),
        .O_run(a_run), .O_hs(a_hs), .O_vs(a_vs), .O_de(a_de),
        .O_x(a_x), .O_y(a_y), .O_sof(a_sof)
    );

    video_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_STABLE(B_LS)
    ) u_dut_b (
        .I_pxl_clk(clk), .I_rst_n(rst_n), .I_pll_lock(lock),
        .O_run(b_run), .O_hs(b_hs), .O_vs(b_vs), .O_de(b_de),
        .O_x(b_x), .O_y(b_y), .O_sof(b_sof)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%08h expected=0x%08h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {run,hs,vs,de,sof,x,y} after `c` consecutive cycles of
    // FSM-visible lock. Output begins once lock has been seen for LS+2 cycles:
    // one cycle to leave WAIT_LOCK, LS cycles in STABLE, one output register.
    function automatic logic [28:0] model_vec(input int c,
            input int ha, input int hfp, input int hs, input int hbp,
            input int va, input int vfp, input int vs, input int vbp,
            input bit hp, input bit vp, input int ls);
        int ht, vt, t, col, line;
        bit de, h_on, v_on, sof;
        ht = ha + hfp + hs + hbp;
        vt = va + vfp + vs + vbp;
        if (c < ls + 2) return {1'b0, ~hp, ~vp, 1'b0, 1'b0, 12'd0, 12'd0};
        t    = c - ls - 2;
        col  = t % ht;
        line = (t / ht) % vt;
        de   = (col < ha) && (line < va);
        h_on = (col >= ha + hfp) && (col < ha + hfp + hs);
        v_on = (line >= va + vfp) && (line < va + vfp + vs);
        sof  = (col == 0) && (line == 0);
        return {1'b1, h_on ? hp : ~hp, v_on ? vp : ~vp, de, sof,
                de ? 12'(col) : 12'd0, de ? 12'(line) : 12'd0};
    endfunction

    function automatic logic [28:0] exp_a_of(input int c);
        return model_vec(c, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, 1'b1, 1'b1, A_LS);
    endfunction

    function automatic logic [28:0] exp_b_of(input int c);
        return model_vec(c, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, 1'b0, 1'b0, B_LS);
    endfunction

    // Reference model state
    bit          d1 = 1'b0, d2 = 1'b0;
    int          c_run = 0;
    logic [28:0] exp_a = exp_a_of(0);
    logic [28:0] exp_b = exp_b_of(0);
    logic [28:0] idle_a = exp_a_of(0);
    logic [28:0] idle_b = exp_b_of(0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1    = 1'b0;
            d2    = 1'b0;
            c_run = 0;
            exp_a = exp_a_of(0);
            exp_b = exp_b_of(0);
        end else begin
            exp_a = exp_a_of(c_run);
            exp_b = exp_b_of(c_run);
            d2    = d1;
            d1    = lock;
            c_run = d2 ? c_run + 1 : 0;
        end
    end

    wire [28:0] a_vec = {a_run, a_hs, a_vs, a_de, a_sof, a_x, a_y};
    wire [28:0] b_vec = {b_run, b_hs, b_vs, b_de, b_sof, b_x, b_y};

    always @(negedge clk) begin
        check_eq("a_cycle", {3'b0, a_vec}, {3'b0, exp_a});
        check_eq("b_cycle", {3'b0, b_vec}, {3'b0, exp_b});
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_pulse(input int low_cycles);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_async_a", {3'b0, a_vec}, {3'b0, idle_a});
        check_eq("rst_async_b", {3'b0, b_vec}, {3'b0, idle_b});
        wait_cyc(low_cycles);
        #2 rst_n = 1'b1;
    endtask

    int lat, n_de, n_hs, n_vs, n_sof, n_run_seen, plen, wait_n;

    initial begin
        // ---- reset state ----
        wait_cyc(3);
        check_eq("reset_a", {3'b0, a_vec}, {3'b0, idle_a});
        check_eq("reset_b", {3'b0, b_vec}, {3'b0, idle_b});
        #2 rst_n = 1'b1;
        $display("txn reset_release t=%0t", $time);

        // ---- lock held: start-up latency and first pixel ----
        wait_cyc(5);
        lock = 1'b1;
        lat = 0;
        while (!a_run && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq("run_latency_a", (lat >= A_LS + 2 && lat <= A_LS + 4), 1);
        check_eq("first_sof_a", a_sof, 1);
        check_eq("first_xy_a", {a_x, a_y}, 0);
        $display("txn lock_start latency=%0d", lat);

        // ---- free run: per-frame region totals ----
        wait_cyc(A_FRAME);
        n_de = 0; n_hs = 0; n_vs = 0; n_sof = 0;
        for (int i = 0; i < A_FRAME; i++) begin
            @(negedge clk);
            n_de  += a_de;
            n_hs  += a_hs;
            n_vs  += a_vs;
            n_sof += a_sof;
        end
        check_eq("a_de_per_frame", n_de, A_HA * A_VA);
        check_eq("a_hs_per_frame", n_hs, A_HS * A_VT);
        check_eq("a_vs_per_frame", n_vs, A_VS * A_HT);
        check_eq("a_sof_per_frame", n_sof, 1);
        n_de = 0; n_hs = 0; n_vs = 0; n_sof = 0;
        for (int i = 0; i < B_FRAME; i++) begin
            @(negedge clk);
            n_de  += b_de;
            n_hs  += !b_hs;
            n_vs  += !b_vs;
            n_sof += b_sof;
        end
        check_eq("b_de_per_frame", n_de, B_HA * B_VA);
        check_eq("b_hs_low_per_frame", n_hs, B_HS * B_VT);
        check_eq("b_vs_low_per_frame", n_vs, B_VS * B_HT);
        check_eq("b_sof_per_frame", n_sof, 1);
        $display("txn free_run frames_checked");

        // ---- short lock pulse must not start the raster ----
        lock = 1'b0;
        wait_cyc($urandom_range(4, 12));
        plen = $urandom_range(2, B_LS - 2);
        lock = 1'b1;
        n_run_seen = 0;
        for (int i = 0; i < plen + 4; i++) begin
            if (i == plen) lock = 1'b0;
            @(negedge clk);
            n_run_seen += a_run | b_run;
        end
        check_eq("pulse_no_run", n_run_seen, 0);
        lock = 1'b1;
        wait_cyc(A_FRAME / 2);
        $display("txn short_pulse len=%0d", plen);

        // ---- lock drop mid-frame, then relock ----
        wait_cyc($urandom_range(1, A_FRAME));
        lock = 1'b0;
        wait_cyc(3);
        check_eq("drop_idle_a", {3'b0, a_vec}, {3'b0, idle_a});
        check_eq("drop_idle_b", {3'b0, b_vec}, {3'b0, idle_b});
        wait_cyc($urandom_range(1, 6));
        lock = 1'b1;
        lat = 0;
        while (!a_run && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq("relock_origin_a", {a_sof, a_x, a_y}, {1'b1, 24'd0});
        $display("txn lock_drop relock_latency=%0d", lat);

        // ---- reset during vertical sync ----
        wait_n = 0;
        while (!a_vs && wait_n < 2 * A_FRAME) begin
            @(negedge clk);
            wait_n++;
        end
        check_eq("vs_reached", a_vs, 1);
        reset_pulse(2);
        n_vs = 0;
        for (int i = 0; i < A_LS + 4; i++) begin
            @(negedge clk);
            n_vs += a_vs;
        end
        check_eq("no_residual_vs", n_vs, 0);
        wait_cyc(A_FRAME);
        $display("txn reset_in_vsync");

        // ---- randomized lock / reset activity ----
        for (int it = 0; it < 25; it++) begin
            lock = $urandom_range(0, 3) != 0;
            wait_cyc($urandom_range(1, 300));
            if ($urandom_range(0, 4) == 0) reset_pulse($urandom_range(1, 4));
            $display("txn random it=%0d lock=%0b", it, lock);
        end

        lock = 1'b1;
        wait_cyc(B_FRAME);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
